// File: rtl/sudoku_pkg.sv
// Shared types and constants for the Sudoku ASCII loader.
package sudoku_pkg;

    localparam int unsigned GRID_DIM   = 9;
    localparam int unsigned CELL_COUNT = GRID_DIM * GRID_DIM;

    typedef logic [3:0] cell_t;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_1     = 8'h31;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_HASH  = 8'h23;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        CLS_DIGIT   = 3'd0,
        CLS_BLANK   = 3'd1,
        CLS_IGNORE  = 3'd2,
        CLS_FRAME   = 3'd3,
        CLS_ILLEGAL = 3'd4
    } class_e;

endpackage

// File: rtl/sudoku_char_decode.sv
// Combinational classifier: maps one ASCII byte to a decode class and cell value.
module sudoku_char_decode (
    input  logic [7:0] data,
    output logic [2:0] cls,
    output logic [3:0] value
);
    import sudoku_pkg::*;

    // Classify the byte; anything not recognised is illegal.
    always_comb begin
        cls   = CLS_ILLEGAL;
        value = 4'd0;
        if (data >= ASCII_1 && data <= ASCII_9) begin
            cls   = CLS_DIGIT;
            value = 4'(data - ASCII_0);
        end else begin
            case (data)
                ASCII_0, ASCII_DOT:                          cls = CLS_BLANK;
                ASCII_SPACE, ASCII_COMMA, ASCII_CR, ASCII_LF: cls = CLS_IGNORE;
                ASCII_HASH:                                  cls = CLS_FRAME;
                default:                                     cls = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/sudoku_ascii_loader.sv
// Sudoku ASCII loader: turns a host byte stream into tagged grid cells.
// Build option: define SUDOKU_LOADER_STRICT_EN to make an illegal byte halt
// loading in the ERR state until restart; otherwise illegal bytes are dropped.
module sudoku_ascii_loader #(
    parameter int unsigned GRID_DIM = sudoku_pkg::GRID_DIM
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [3:0] cell_value,
    output logic [3:0] cell_row,
    output logic [3:0] cell_col,
    output logic       cell_valid,
    input  logic       cell_ready,
    output logic       grid_done,
    output logic       check_trigger,
    output logic       parse_err,
    input  logic       restart
);
    import sudoku_pkg::*;

    localparam logic [3:0] LAST = 4'(GRID_DIM - 1);

    state_e     state;
    state_e     next_state;
    logic [3:0] row;
    logic [3:0] col;
    logic [2:0] cls_raw;
    class_e     byte_cls;
    cell_t      dec_value;
    logic       take;
    logic       emit;
    logic       accept_out;
    logic       last_cell;
    logic       restart_ok;

    sudoku_char_decode u_decode (
        .data  (rx_data),
        .cls   (cls_raw),
        .value (dec_value)
    );

    assign byte_cls   = class_e'(cls_raw);
    assign take       = rx_valid && rx_ready;
    assign emit       = take && (byte_cls == CLS_DIGIT || byte_cls == CLS_BLANK);
    assign accept_out = cell_valid && cell_ready;
    assign last_cell  = (row == LAST) && (col == LAST);
    assign restart_ok = restart && (state == ST_DONE || state == ST_ERR);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_LOAD;
        else        state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_LOAD: begin
                if (emit && last_cell) begin
                    next_state = ST_FLUSH;
                end
`ifdef SUDOKU_LOADER_STRICT_EN
                else if (take && byte_cls == CLS_ILLEGAL) begin
                    next_state = ST_ERR;
                end
`endif
            end
            ST_FLUSH: if (accept_out) next_state = ST_DONE;
            ST_DONE,
            ST_ERR:   if (restart) next_state = ST_LOAD;
            default:  next_state = ST_LOAD;
        endcase
    end

    // Byte acceptance: only in LOAD with room in the output register; held low in reset.
    always_comb begin
        rx_ready = 1'b0;
        if (rst_n && state == ST_LOAD && (!cell_valid || cell_ready)) rx_ready = 1'b1;
    end

    // Output register, grid coordinates and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_valid    <= 1'b0;
            cell_value    <= 4'd0;
            cell_row      <= 4'd0;
            cell_col      <= 4'd0;
            row           <= 4'd0;
            col           <= 4'd0;
            parse_err     <= 1'b0;
            grid_done     <= 1'b0;
            check_trigger <= 1'b0;
        end else begin
            if (emit) begin
                cell_valid <= 1'b1;
                cell_value <= dec_value;
                cell_row   <= row;
                cell_col   <= col;
            end else if (accept_out) begin
                cell_valid <= 1'b0;
            end

            if (emit) begin
                if (col == LAST) begin
                    col <= 4'd0;
                    row <= last_cell ? 4'd0 : row + 4'd1;
                end else begin
                    col <= col + 4'd1;
                end
            end else if ((take && byte_cls == CLS_FRAME) || restart_ok) begin
                row <= 4'd0;
                col <= 4'd0;
            end

            if ((take && byte_cls == CLS_FRAME) || restart_ok) parse_err <= 1'b0;
            else if (take && byte_cls == CLS_ILLEGAL)           parse_err <= 1'b1;

            grid_done     <= (next_state == ST_DONE);
            check_trigger <= (state == ST_FLUSH) && (next_state == ST_DONE);
        end
    end

endmodule

// File: tb/tb_sudoku_ascii_loader.sv
// Randomised scoreboard bench for sudoku_ascii_loader.
module tb_sudoku_ascii_loader;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [3:0] cell_value;
    logic [3:0] cell_row;
    logic [3:0] cell_col;
    logic       cell_valid;
    logic       cell_ready;
    logic       grid_done;
    logic       check_trigger;
    logic       parse_err;
    logic       restart;

    sudoku_ascii_loader #(.GRID_DIM(9)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .cell_value    (cell_value),
        .cell_row      (cell_row),
        .cell_col      (cell_col),
        .cell_valid    (cell_valid),
        .cell_ready    (cell_ready),
        .grid_done     (grid_done),
        .check_trigger (check_trigger),
        .parse_err     (parse_err),
        .restart       (restart)
    );

    typedef struct {
        int row;
        int col;
        int val;
    } exp_t;

    exp_t q[$];
    int   errors     = 0;
    int   checks     = 0;
    int   idx        = 0;   // cells emitted so far in the current frame
    int   exp_perr   = 0;
    int   trig_count = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
    bit   held       = 0;
    int   held_v, held_r, held_c;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: applies the decode rules to every transferred byte.
    function automatic void push_cell(input int v);
        exp_t e;
        e.row = idx / 9;
        e.col = idx % 9;
        e.val = v;
        q.push_back(e);
        idx++;
        if (idx == 81) idx = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b >= "1" && b <= "9")                                   push_cell(int'(b) - 48);
        else if (b == "0" || b == ".")                              push_cell(0);
        else if (b == " " || b == "," || b == 8'h0d || b == 8'h0a) begin end
        else if (b == "#") begin idx = 0; exp_perr = 0; end
        else exp_perr = 1;
    endfunction

    // Monitor: drives cell_ready and scores every accepted cell.
    initial begin
        cell_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       cell_ready = 1'b1;
                1:       cell_ready = ($urandom_range(0, 3) != 0);
                default: cell_ready = 1'b0;
            endcase
            #1;
            if (rst_n && cell_valid) begin
                if (held) begin
                    check_eq("held_value", int'(cell_value), held_v);
                    check_eq("held_row", int'(cell_row), held_r);
                    check_eq("held_col", int'(cell_col), held_c);
                end
                if (cell_ready) begin
                    held = 0;
                    if (q.size() == 0) begin
                        check_eq("unexpected_cell", 1, 0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check_eq("cell_row", int'(cell_row), e.row);
                        check_eq("cell_col", int'(cell_col), e.col);
                        check_eq("cell_value", int'(cell_value), e.val);
                    end
                end else begin
                    held   = 1;
                    held_v = int'(cell_value);
                    held_r = int'(cell_row);
                    held_c = int'(cell_col);
                end
            end else begin
                held = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (check_trigger) trig_count++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bit done = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!done) begin
            #2;
            if (rx_ready) begin
                @(posedge clk);
                model_byte(b);
                done = 1;
            end else begin
                n++;
                if (n > 500) begin
                    check_eq("rx_ready_timeout", 0, 1);
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || cell_valid) && n < 2000) begin
            @(negedge clk);
            #3;
            n++;
        end
        check_eq("drain_pending", q.size(), 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!grid_done && n < 2000) begin
            @(negedge clk);
            #3;
            n++;
        end
        check_eq("grid_done_reached", int'(grid_done), 1);
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart  = 1'b0;
        idx      = 0;
        exp_perr = 0;
        #3;
    endtask

    initial begin
        int cnt;
        logic [7:0] c;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        restart  = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_rx_ready", int'(rx_ready), 0);
        check_eq("rst_cell_valid", int'(cell_valid), 0);
        check_eq("rst_grid_done", int'(grid_done), 0);
        check_eq("rst_parse_err", int'(parse_err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        #3;
        check_eq("post_rst_rx_ready", int'(rx_ready), 1);

        // Digits, blanks and ignored characters.
        send_str("5 3 .\r\n");
        drain();

        // Frame reset mid-line.
        send_str("#12#7");
        drain();

        // Back-pressure: one cell buffered, next byte must wait.
        send_byte("#");
        ready_mode = 2;
        send_byte("3");
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = "4";
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #3;
            check_eq("stall_rx_ready", int'(rx_ready), 0);
            check_eq("stall_cell_valid", int'(cell_valid), 1);
        end
        rx_valid   = 1'b0;
        ready_mode = 0;
        send_byte("4");
        drain();

        // Illegal byte mid-frame.
        send_str("#1x");
        drain();
        check_eq("illegal_parse_err", int'(parse_err), 1);
`ifdef SUDOKU_LOADER_STRICT_EN
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #3;
            check_eq("err_rx_ready", int'(rx_ready), 0);
        end
        pulse_restart();
        check_eq("err_restart_parse_err", int'(parse_err), 0);
        check_eq("err_restart_rx_ready", int'(rx_ready), 1);
`endif
        send_byte("4");
        drain();
        send_byte("#");
        @(negedge clk);
        #3;
        check_eq("hash_clears_parse_err", int'(parse_err), exp_perr);

        // Random full frame under random back-pressure.
        ready_mode = 1;
        trig_count = 0;
        cnt = 0;
        while (cnt < 81) begin
            case ($urandom_range(0, 9))
                0:       c = " ";
                1:       c = ",";
                2:       c = 8'h0a;
                3:       c = ".";
                4:       c = "0";
                default: c = 8'(48 + $urandom_range(1, 9));
            endcase
            if (c == "." || c == "0" || (c >= "1" && c <= "9")) cnt++;
            send_byte(c);
        end
        wait_done();
        drain();
        repeat (2) @(negedge clk);
        #3;
        check_eq("rand_trigger_count", trig_count, 1);
        check_eq("rand_done_rx_ready", int'(rx_ready), 0);
        pulse_restart();
        check_eq("restart_grid_done", int'(grid_done), 0);
        check_eq("restart_rx_ready", int'(rx_ready), 1);

        // Full frame of 1..9 repeated with constant ready.
        ready_mode = 0;
        trig_count = 0;
        for (int i = 0; i < 81; i++) send_byte(8'(49 + (i % 9)));
        wait_done();
        drain();
        repeat (2) @(negedge clk);
        #3;
        check_eq("seq_trigger_count", trig_count, 1);
        check_eq("seq_grid_done", int'(grid_done), 1);
        pulse_restart();

        // Reset mid-frame with a cell pending.
        for (int i = 0; i < 40; i++) send_byte(8'(49 + (i % 9)));
        drain();
        ready_mode = 2;
        send_byte("6");
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_cell_valid", int'(cell_valid), 0);
        check_eq("midrst_cell_value", int'(cell_value), 0);
        check_eq("midrst_rx_ready", int'(rx_ready), 0);
        check_eq("midrst_grid_done", int'(grid_done), 0);
        q.delete();
        idx      = 0;
        exp_perr = 0;
        ready_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send_byte("7");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
